// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
//   ARB_STATE_LENGTH : width of the arbiter state register
//   arb_state_e      : ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK
//   owner_e          : OWNER_IF (fetch) = 0, OWNER_DM (data) = 1
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_LENGTH = 2;

  typedef enum logic [ARB_STATE_LENGTH-1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_priority.sv
// Grant decision between fetch and data requesters, plus the fetch
// starvation counter.
//   clk, rst      : clock, asynchronous active-low reset
//   if_req/dm_req : level requests from fetch and data stages
//   arb_en        : high while the arbiter is able to grant (IDLE)
//   grant_valid   : at least one requester is active
//   grant_owner   : which requester wins this cycle
module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   arb_en,
  output logic   grant_valid,
  output owner_e grant_owner
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  // Consecutive data grants taken while fetch was also waiting.
  logic [SC_W-1:0] starve_cnt;

  // Data wins ties unless fetch has already been passed over SC_MAX times.
  always_comb begin
    grant_valid = if_req | dm_req;
    grant_owner = OWNER_IF;
    if (dm_req && !(if_req && (starve_cnt == SC_MAX))) begin
      grant_owner = OWNER_DM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (arb_en && grant_valid) begin
      if (grant_owner == OWNER_IF) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != SC_MAX)) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data memory. Each transaction walks IDLE -> ISSUE -> WAIT -> ACK.
//   clk, rst                     : clock, asynchronous active-low reset
//   if_req/if_addr               : fetch request and address
//   if_rdata/if_ack              : fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata: data request, direction, address, store data
//   dm_rdata/dm_ack              : load data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
//   pause                        : stall for PC, IF_ID and ID_EXE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pause
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_e       state;
  owner_e           owner;
  logic             we_lat;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_valid;
  owner_e           grant_owner;

  arb_priority #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .dm_req      (dm_req),
    .arb_en      (state == ARB_IDLE),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign pause = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  // Address, write data and direction are captured straight into the memory
  // port registers at grant, so they appear during ISSUE and later input
  // changes cannot disturb the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      owner     <= OWNER_IF;
      we_lat    <= 1'b0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner  <= grant_owner;
            mem_en <= 1'b1;
            if (grant_owner == OWNER_DM) begin
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_we    <= dm_we;
              we_lat    <= dm_we;
            end else begin
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
              we_lat   <= 1'b0;
            end
            state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= CNT_W'(MEM_LAT);
          state    <= ARB_WAIT;
        end
        ARB_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          // Count of 1 marks the cycle the memory presents its read data.
          if (wait_cnt == CNT_W'(1)) begin
            if (owner == OWNER_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!we_lat) begin
                dm_rdata <= mem_rdata;
              end
              dm_ack <= 1'b1;
            end
            state <= ARB_ACK;
          end
        end
        ARB_ACK: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
